keccak_byte_packer: RTL and testbench

Upstream feeder for the `keccak` core. It accepts a byte stream with per-message framing and packs the bytes MSB-first into 32-bit words on the core's `in`/`in_ready`/`is_last`/`byte_num` interface, honouring `buffer_full` backpressure. It produces the zero-length final word when the message length is a multiple of 4. It also sequences per-message core resets: after the digest is acknowledged, it issues a one-cycle `core_reset` so the next message starts from a clean sponge state.

---
 rtl/keccak_byte_packer.sv | 122 ++++++++++++
 tb/tb_keccak_byte_packer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_byte_packer.sv
// Byte-stream front end for the keccak core: packs framed bytes MSB-first into
// 32-bit words, always emits a final word, and pulses core_reset between messages.
module keccak_byte_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    input  logic        empty_msg,
    output logic        byte_ready,
    output logic [31:0] in,
    output logic        in_ready,
    output logic        is_last,
    output logic [1:0]  byte_num,
    input  logic        buffer_full,
    input  logic        out_ready,
    input  logic        digest_ack,
    output logic        core_reset
);

    typedef enum logic [1:0] {CORE_RST, FILL, FLUSH, WAIT_DIGEST} state_t;

    state_t          state;
    logic [2:0][7:0] acc;
    logic [1:0]      acc_cnt;

    logic        word_fire;
    logic        reg_free;
    logic        beat_fire;
    logic [31:0] full_word;
    logic [31:0] flush_word;

    assign word_fire = in_ready && !buffer_full;
    assign reg_free  = !in_ready || word_fire;
    assign beat_fire = byte_valid && byte_ready;
    assign full_word = {acc[0], acc[1], acc[2], byte_in};

    // Depends only on registered state so upstream sees no combinational loop
    // through byte_valid or buffer_full.
    always_comb begin
        byte_ready = (state == FILL) && ((acc_cnt != 2'd3) || !in_ready);
    end

    // Left-align the leftover bytes; stale accumulator contents are masked off.
    always_comb begin
        flush_word = '0;
        case (acc_cnt)
            2'd1:    flush_word = {acc[0], 24'h0};
            2'd2:    flush_word = {acc[0], acc[1], 16'h0};
            2'd3:    flush_word = {acc[0], acc[1], acc[2], 8'h0};
            default: flush_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CORE_RST;
            core_reset <= 1'b1;
            acc        <= '0;
            acc_cnt    <= 2'd0;
            in         <= '0;
            in_ready   <= 1'b0;
            is_last    <= 1'b0;
            byte_num   <= 2'd0;
        end else begin
            if (word_fire) begin
                in_ready <= 1'b0;
                in       <= '0;
                is_last  <= 1'b0;
                byte_num <= 2'd0;
            end
            case (state)
                CORE_RST: begin
                    core_reset <= 1'b0;
                    state      <= FILL;
                end
                FILL: begin
                    if (beat_fire) begin
                        if (empty_msg) begin
                            acc_cnt <= 2'd0;
                            state   <= FLUSH;
                        end else if (acc_cnt == 2'd3) begin
                            // byte_ready guarantees the output register is idle here
                            in       <= full_word;
                            in_ready <= 1'b1;
                            is_last  <= 1'b0;
                            byte_num <= 2'd0;
                            acc_cnt  <= 2'd0;
                            if (byte_last) state <= FLUSH;
                        end else begin
                            case (acc_cnt)
                                2'd0:    acc[0] <= byte_in;
                                2'd1:    acc[1] <= byte_in;
                                default: acc[2] <= byte_in;
                            endcase
                            acc_cnt <= acc_cnt + 2'd1;
                            if (byte_last) state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (reg_free) begin
                        in       <= flush_word;
                        in_ready <= 1'b1;
                        is_last  <= 1'b1;
                        byte_num <= acc_cnt;
                        acc_cnt  <= 2'd0;
                        state    <= WAIT_DIGEST;
                    end
                end
                WAIT_DIGEST: begin
                    if (out_ready && digest_ack) begin
                        state      <= CORE_RST;
                        core_reset <= 1'b1;
                    end
                end
                default: state <= CORE_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Bench for keccak_byte_packer: directed framing cases plus random messages,
// checked against a scoreboard of words derived from each message's bytes.
module tb_keccak_byte_packer;

    logic        clk;
    logic        reset_n;
    logic [7:0]  byte_in;
    logic        byte_valid, byte_last, empty_msg;
    logic        byte_ready;
    logic [31:0] in;
    logic        in_ready, is_last;
    logic [1:0]  byte_num;
    logic        buffer_full, out_ready, digest_ack;
    logic        core_reset;

    keccak_byte_packer dut (
        .clk(clk), .reset_n(reset_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_last(byte_last), .empty_msg(empty_msg), .byte_ready(byte_ready),
        .in(in), .in_ready(in_ready), .is_last(is_last), .byte_num(byte_num),
        .buffer_full(buffer_full), .out_ready(out_ready), .digest_ack(digest_ack),
        .core_reset(core_reset)
    );

    typedef logic [7:0] bq_t [$];

    int vectors = 0;
    int miscompares = 0;
    logic [34:0] exp_q [$];   // {is_last, byte_num, word}
    bit  bf_mode = 0;
    logic [34:0] held;
    bit  held_v = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected words: floor(n/4) full words, then a final word with n%4 bytes.
    function automatic void push_msg(input bq_t m);
        int n = m.size();
        int r = n % 4;
        logic [31:0] w;
        for (int i = 0; i < n / 4; i++)
            exp_q.push_back({1'b0, 2'd0, m[4*i], m[4*i+1], m[4*i+2], m[4*i+3]});
        w = '0;
        for (int j = 0; j < r; j++) w[31-8*j -: 8] = m[4*(n/4)+j];
        exp_q.push_back({1'b1, 2'(r), w});
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Word scoreboard and hold-stability monitor.
    always @(negedge clk) begin
        if (reset_n && in_ready && !buffer_full) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL spurious_word observed=%h expected=none", {is_last, byte_num, in});
            end
            if (exp_q.size() != 0) chk("word", {is_last, byte_num, in}, exp_q.pop_front());
        end
        if (reset_n && in_ready && buffer_full) begin
            if (held_v) chk("hold_stable", {is_last, byte_num, in}, held);
            held   <= {is_last, byte_num, in};
            held_v <= 1;
        end else begin
            held_v <= 0;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (bf_mode) buffer_full = ($urandom_range(0, 2) == 0);
        end
    end

    task automatic send_beat(input logic [7:0] b, input bit last, input bit emp);
        int n = 0;
        bit acc = 0;
        byte_in = b; byte_valid = 1; byte_last = last; empty_msg = emp;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = byte_ready;
            n++;
        end
        if (!acc) chk("beat_timeout", 35'(acc), 35'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        if (n > 0) begin
            byte_valid = 0; byte_last = 0; empty_msg = 0;
            repeat (n) begin @(posedge clk); #1; end
        end
    endtask

    task automatic send_msg(input bq_t m, input int gap_max);
        push_msg(m);
        if (m.size() == 0) send_beat(8'($urandom), 1, 1);
        else
            for (int i = 0; i < m.size(); i++) begin
                if (gap_max > 0) idle($urandom_range(0, gap_max));
                send_beat(m[i], i == m.size() - 1, 0);
            end
        byte_valid = 0; byte_last = 0; empty_msg = 0;
    endtask

    task automatic finish_msg(input bit stall);
        int n = 0;
        while (!(exp_q.size() == 0 && !in_ready) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", 35'(exp_q.size()), 35'd0);
        if (stall) begin
            out_ready = 1; digest_ack = 0;
            repeat (5) begin
                @(negedge clk);
                chk("noack_core_reset", 35'(core_reset), 35'd0);
            end
            @(posedge clk); #1;
            out_ready = 0; digest_ack = 1;
            repeat (2) begin
                @(negedge clk);
                chk("ack_wo_outready", 35'(core_reset), 35'd0);
            end
            @(posedge clk); #1;
        end
        out_ready = 1; digest_ack = 1;
        @(negedge clk);
        chk("pre_core_reset", 35'(core_reset), 35'd0);
        @(posedge clk); #1;
        out_ready = 0; digest_ack = 0;
        @(negedge clk);
        chk("core_reset_hi", 35'(core_reset), 35'd1);
        chk("core_rst_bready", 35'(byte_ready), 35'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("core_reset_lo", 35'(core_reset), 35'd0);
        chk("fill_bready", 35'(byte_ready), 35'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        bq_t m;
        reset_n = 0; byte_in = 0; byte_valid = 0; byte_last = 0; empty_msg = 0;
        buffer_full = 0; out_ready = 0; digest_ack = 0;

        // Power-up
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_core_reset", 35'(core_reset), 35'd1);
        chk("rst_outs", {byte_ready, in_ready, is_last, byte_num, in}, 37'd0);
        @(posedge clk); #1;
        reset_n = 1;
        @(negedge clk);
        chk("rel_core_reset", 35'(core_reset), 35'd1);
        chk("rel_bready", 35'(byte_ready), 35'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel2_core_reset", 35'(core_reset), 35'd0);
        chk("rel2_bready", 35'(byte_ready), 35'd1);
        @(posedge clk); #1;

        // Hello, world!
        send_msg(str2q("Hello, world!"), 0);
        finish_msg(0);

        // Exact multiple of 4, with load latency check
        m = str2q("Hell");
        push_msg(m);
        for (int i = 0; i < 4; i++) send_beat(m[i], i == 3, 0);
        byte_valid = 0; byte_last = 0;
        chk("latency_word", {in_ready, is_last, byte_num, in}, {1'b1, 1'b0, 2'd0, 32'h48656C6C});
        finish_msg(0);

        // Empty message, then digest handshake corner cases
        m.delete();
        send_msg(m, 0);
        finish_msg(1);

        // Backpressure
        m = str2q("The quick");
        push_msg(m);
        for (int i = 0; i < 3; i++) send_beat(m[i], 0, 0);
        buffer_full = 1;
        send_beat(m[3], 0, 0);
        for (int i = 4; i < 7; i++) send_beat(m[i], 0, 0);
        byte_valid = 0;
        repeat (6) begin
            @(negedge clk);
            chk("bp_bready", {byte_ready, in_ready, in}, {1'b0, 1'b1, 32'h54686520});
        end
        @(posedge clk); #1;
        buffer_full = 0;
        send_beat(m[7], 0, 0);
        send_beat(m[8], 1, 0);
        byte_valid = 0; byte_last = 0;
        finish_msg(0);

        // Reset mid-message while a word is presented
        buffer_full = 1;
        m = str2q("abcde");
        for (int i = 0; i < 5; i++) send_beat(m[i], 0, 0);
        byte_valid = 0;
        @(negedge clk); #2;
        reset_n = 0;
        #1;
        chk("async_in_ready", {in_ready, core_reset, byte_ready}, {1'b0, 1'b1, 1'b0});
        exp_q.delete();
        buffer_full = 0;
        @(posedge clk); #1;
        reset_n = 1;
        @(negedge clk);
        chk("mid_rst_core_reset", 35'(core_reset), 35'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_bready", {byte_ready, core_reset}, {1'b1, 1'b0});
        @(posedge clk); #1;
        send_msg(str2q("Hi"), 0);
        finish_msg(0);

        // Random messages with gaps and random backpressure
        bf_mode = 1;
        for (int k = 0; k < 25; k++) begin
            bq_t r;
            int len = $urandom_range(0, 19);
            for (int j = 0; j < len; j++) r.push_back(8'($urandom));
            send_msg(r, 2);
            finish_msg(k % 8 == 3);
        end
        bf_mode = 0;
        buffer_full = 0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
